tmp10x_reg_ctrl: RTL
====================

// Module: tmp10x_reg_ctrl
// PURPOSE
//  Register/transaction controller for the TMP10X-style sensor, between I2C_SLAVE_UC byte handshakes and sensor state.
//  Decodes pointer byte, sequences MSB/LSB register writes and reads, holds TEMP/CONFIG/TLOW/THIGH.
//  Runs the ALERT thermostat with fault queue; requests conversions (continuous, shutdown, one-shot).
// PARAMETERS
//  TEMP_WIDTH   12       temperature width, two's complement, left-justified in 16-bit regs
//  CONFIG_RST   8'h00    CONFIG reset value
//  TLOW_RST     16'h4B00 TLOW reset value (75 C)
//  THIGH_RST    16'h5000 THIGH reset value (80 C)
// PORTS
//  CLK         in   1   single system clock, rising edge
//  RST_N       in   1   asynchronous active-low reset
//  START       in   1   1-cycle pulse: START or repeated START detected
//  STOP        in   1   1-cycle pulse: STOP detected
//  ADDR_HIT    in   1   1-cycle pulse: own address matched; RORW valid same cycle
//  RORW        in   1   1 = master read, 0 = master write
//  RX_VALID    in   1   1-cycle pulse: RX_DATA holds a received byte
//  RX_DATA     in   8   received byte
//  TX_REQ      in   1   1-cycle pulse: UC needs next read byte
//  TX_DATA     out  8   byte for UC; valid cycle after TX_REQ, held until next TX_REQ
//  TEMP_VALID  in   1   1-cycle pulse: conversion done
//  TEMP_IN     in   TEMP_WIDTH  conversion result
//  CONV_EN     out  1   1 = converter runs continuously
//  ONESHOT     out  1   1-cycle pulse: single conversion request
//  ALERT       out  1   alert pin level, polarity per CONFIG.POL
//  POINTER     out  2   current pointer register (debug)
// BEHAVIOUR
//  Reset: POINTER=0, TEMP=0, CONFIG=CONFIG_RST, TLOW/THIGH=*_RST, TX_DATA=0, fault cnt=0, alert_int=0, FSM=IDLE.
//  Reset mid-transaction aborts it; no partial write commits.
//  Regs by pointer: 0 TEMP (RO), 1 CONFIG (8b), 2 TLOW, 3 THIGH (16b, low 16-TEMP_WIDTH bits read 0).
//  CONFIG: [0]SD [1]TM [2]POL [4:3]F fault queue 1/2/4/6 [6:5]R resolution 9/10/11/12b [7]OS (reads 0).
//  FSM: IDLE -ADDR_HIT&!RORW-> PTR; IDLE -ADDR_HIT&RORW-> RD.
//   PTR -RX_VALID-> POINTER<=RX_DATA[1:0]; ->WMSB (ptr 1,2,3) or WIGN (ptr 0).
//   WMSB -RX_VALID-> hold byte; CONFIG commits here ->WIGN; TLOW/THIGH ->WLSB.
//   WLSB -RX_VALID-> commit {msb,lsb} same edge ->WIGN. WIGN ignores further bytes.
//   RD: TX_REQ 1 = MSB (CONFIG byte for ptr 1); then alternates LSB,MSB,... (CONFIG repeats).
//   START or STOP from any state -> IDLE, POINTER kept; uncommitted MSB dropped.
//  TEMP coherence: at MSB TX_REQ of ptr 0, snapshot TEMP to shadow; LSB from shadow.
//  TEMP update on TEMP_VALID: low (12-res) bits zeroed per R; loads even mid-read.
//  Conversion: CONV_EN = !SD. Write CONFIG with OS=1 & SD=1 -> ONESHOT pulses the next cycle.
//   TEMP_VALID while SD=1 & no one-shot pending is ignored.
//  Thermostat, per TEMP_VALID, signed TEMP_WIDTH compare: hi = T>=THIGH, lo = T<TLOW.
//   Fault cnt counts consecutive hi (when !alert_int) or lo (when alert_int) results; reset on other result.
//   cnt reaching F-limit toggles alert_int, cnt<=0. Saturates; no wrap.
//   TM=0 comparator: alert_int set as above, cleared by lo run.
//   TM=1 interrupt: also cleared on any RD TX_REQ; next armed condition is opposite side.
//   ALERT = alert_int ^ !POL (POL=0 active-low, pin idles 1). Registered, 1 cycle after TEMP_VALID.
//  Write to TM/F clears fault cnt; alert_int kept. TEMP_VALID and CONFIG commit in same cycle: commit first.
//  RX_VALID in IDLE or RD, or TX_REQ outside RD: ignored, no state change.
// TESTING
//  Reset -> ALERT=1, CONV_EN=1, POINTER=0, read ptr0 -> 00,00.
//  Write 03,50,80 -> THIGH=16'h5080; read ptr3 -> 50,80,50.
//  TEMP_IN=12'h510 x1, F=0, POL=0 -> ALERT=0 next cycle; TEMP_IN=12'h4A0 -> ALERT=1.
//  F=2'b10, 3 hot samples then 1 cold then 4 hot -> ALERT low only after 4th consecutive hot.
//  Write 01,81 -> CONV_EN=0, one ONESHOT pulse; TEMP_VALID latched once, second ignored.
//  Write 02,4B then STOP -> TLOW unchanged 16'h4B00 clear; POINTER=2; then TM=1 read clears ALERT.

Source files
------------

// File: rtl/tmp10x_reg_ctrl.sv
// TMP10X-style register/transaction controller: pointer decode, register
// write/read sequencing, conversion control and the ALERT thermostat.
module tmp10x_reg_ctrl #(
  parameter int          TEMP_WIDTH = 12,
  parameter logic [7:0]  CONFIG_RST = 8'h00,
  parameter logic [15:0] TLOW_RST   = 16'h4B00,
  parameter logic [15:0] THIGH_RST  = 16'h5000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  addr_hit,
  input  logic                  rorw,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  tx_req,
  output logic [7:0]            tx_data,
  input  logic                  temp_valid,
  input  logic [TEMP_WIDTH-1:0] temp_in,
  output logic                  conv_en,
  output logic                  oneshot,
  output logic                  alert,
  output logic [1:0]            pointer
);

  localparam int          PAD      = 16 - TEMP_WIDTH;
  localparam logic [15:0] THR_MASK = 16'hFFFF << PAD;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PTR  = 3'd1;
  localparam logic [2:0] ST_WMSB = 3'd2;
  localparam logic [2:0] ST_WLSB = 3'd3;
  localparam logic [2:0] ST_WIGN = 3'd4;
  localparam logic [2:0] ST_RD   = 3'd5;

  logic [2:0]            state;
  logic [15:0]           temp_reg;
  logic [7:0]            shadow;
  logic [6:0]            cfg;
  logic [15:0]           tlow;
  logic [15:0]           thigh;
  logic [7:0]            msb_hold;
  logic                  rd_lsb;
  logic [2:0]            fault_cnt;
  logic                  alert_int;
  logic                  side;
  logic                  os_pending;

  logic                  abort;
  logic                  cfg_wr;
  logic                  thr_wr;
  logic                  rd_req;
  logic                  os_req;
  logic [6:0]            cfg_nxt;
  logic [15:0]           tlow_nxt;
  logic [15:0]           thigh_nxt;
  logic                  temp_acc;
  logic [TEMP_WIDTH-1:0] temp_m;
  logic                  hi;
  logic                  lo;
  logic                  armed;
  logic                  cond;
  logic [2:0]            limit;
  logic [2:0]            cnt_base;
  logic                  alert_base;
  logic [2:0]            cnt_nxt;
  logic                  alert_nxt;
  logic                  side_nxt;
  logic [7:0]            rd_byte;

  assign abort   = start | stop;
  assign cfg_wr  = !abort && rx_valid && (state == ST_WMSB) && (pointer == 2'd1);
  assign thr_wr  = !abort && rx_valid && (state == ST_WLSB);
  assign rd_req  = !abort && tx_req && (state == ST_RD);
  assign os_req  = cfg_wr && rx_data[7] && rx_data[0];
  assign conv_en = !cfg[0];

  // A CONFIG/threshold commit in the same cycle as a conversion result takes
  // effect before that result is evaluated.
  always_comb begin
    cfg_nxt   = cfg_wr ? rx_data[6:0] : cfg;
    tlow_nxt  = (thr_wr && pointer == 2'd2) ? ({msb_hold, rx_data} & THR_MASK) : tlow;
    thigh_nxt = (thr_wr && pointer == 2'd3) ? ({msb_hold, rx_data} & THR_MASK) : thigh;
  end

  always_comb begin
    int zs;
    zs = TEMP_WIDTH - 9 - int'(cfg_nxt[6:5]);
    if (zs < 0) zs = 0;
    temp_m   = temp_in & ({TEMP_WIDTH{1'b1}} << zs);
    temp_acc = temp_valid && (!cfg_nxt[0] || os_pending);
    hi       = $signed(temp_m) >= $signed(thigh_nxt[15 -: TEMP_WIDTH]);
    lo       = $signed(temp_m) <  $signed(tlow_nxt[15 -: TEMP_WIDTH]);
    case (cfg_nxt[4:3])
      2'd0:    limit = 3'd1;
      2'd1:    limit = 3'd2;
      2'd2:    limit = 3'd4;
      default: limit = 3'd6;
    endcase
  end

  // In interrupt mode the armed side is tracked separately because a read
  // clears alert_int without changing which threshold is watched next.
  always_comb begin
    cnt_base   = (cfg_wr && (rx_data[4:3] != cfg[4:3] || rx_data[1] != cfg[1])) ? 3'd0 : fault_cnt;
    alert_base = (rd_req && cfg_nxt[1]) ? 1'b0 : alert_int;
    armed      = cfg_nxt[1] ? side : alert_int;
    cond       = armed ? lo : hi;
    cnt_nxt    = cnt_base;
    alert_nxt  = alert_base;
    side_nxt   = side;
    if (temp_acc) begin
      if (cond) begin
        if (({1'b0, cnt_base} + 4'd1) >= {1'b0, limit}) begin
          alert_nxt = !alert_base;
          side_nxt  = !armed;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt_base + 3'd1;
        end
      end else begin
        cnt_nxt = 3'd0;
      end
    end
  end

  always_comb begin
    case (pointer)
      2'd0:    rd_byte = rd_lsb ? shadow : temp_reg[15:8];
      2'd1:    rd_byte = {1'b0, cfg};
      2'd2:    rd_byte = rd_lsb ? tlow[7:0] : tlow[15:8];
      default: rd_byte = rd_lsb ? thigh[7:0] : thigh[15:8];
    endcase
  end

  // Transaction sequencing; START/STOP always return to IDLE keeping the pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pointer  <= 2'd0;
      msb_hold <= 8'h00;
      rd_lsb   <= 1'b0;
      tx_data  <= 8'h00;
      shadow   <= 8'h00;
    end else if (abort) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (addr_hit) begin
          state  <= rorw ? ST_RD : ST_PTR;
          rd_lsb <= 1'b0;
        end
        ST_PTR: if (rx_valid) begin
          pointer <= rx_data[1:0];
          state   <= (rx_data[1:0] == 2'd0) ? ST_WIGN : ST_WMSB;
        end
        ST_WMSB: if (rx_valid) begin
          msb_hold <= rx_data;
          state    <= (pointer == 2'd1) ? ST_WIGN : ST_WLSB;
        end
        ST_WLSB: if (rx_valid) state <= ST_WIGN;
        ST_WIGN: state <= ST_WIGN;
        ST_RD: if (tx_req) begin
          rd_lsb  <= !rd_lsb;
          tx_data <= rd_byte;
          if (pointer == 2'd0 && !rd_lsb) shadow <= temp_reg[7:0];
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg        <= CONFIG_RST[6:0];
      tlow       <= TLOW_RST;
      thigh      <= THIGH_RST;
      temp_reg   <= 16'h0000;
      fault_cnt  <= 3'd0;
      alert_int  <= 1'b0;
      side       <= 1'b0;
      os_pending <= 1'b0;
      oneshot    <= 1'b0;
      alert      <= !CONFIG_RST[2];
    end else begin
      cfg       <= cfg_nxt;
      tlow      <= tlow_nxt;
      thigh     <= thigh_nxt;
      fault_cnt <= cnt_nxt;
      alert_int <= alert_nxt;
      side      <= side_nxt;
      oneshot   <= os_req;
      alert     <= alert_nxt ^ !cfg_nxt[2];
      if (temp_acc) temp_reg <= 16'(temp_m) << PAD;
      if (os_req) os_pending <= 1'b1;
      else if (!cfg_nxt[0] || (temp_valid && os_pending)) os_pending <= 1'b0;
    end
  end

endmodule
